// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the CPU/loader RAM port arbiter.
// Default widths match the control unit and datapath word size.
package ram_arb_pkg;

   localparam int ARB_ADDR_W       = 16;
   localparam int ARB_DATA_W       = 16;
   localparam int ARB_WAIT_W       = 8;
   localparam int ARB_STARVE_LIMIT = 64;

   typedef enum logic {
      ARB_IDLE   = 1'b0,
      ARB_LDR_RD = 1'b1
   } arb_state_t;

   // Which master drives the RAM in the current cycle
   localparam logic OWNER_CPU = 1'b0;
   localparam logic OWNER_LDR = 1'b1;

endpackage

// File: rtl/ram_arb_wait_counter.sv
// Saturating count of consecutive ungranted loader-request cycles, with a
// registered flag raised once the count reaches STARVE_LIMIT.
module ram_arb_wait_counter
   import ram_arb_pkg::*;
#(
   parameter int WAIT_W       = ARB_WAIT_W,
   parameter int STARVE_LIMIT = ARB_STARVE_LIMIT
) (
   input  logic clk,
   input  logic reset,
   input  logic ldr_req,
   input  logic ldr_gnt,
   output logic ldr_starved
);

   logic [WAIT_W-1:0] cnt;
   logic [WAIT_W-1:0] cnt_nxt;

   always_comb begin
      cnt_nxt = cnt;
      if (!ldr_req || ldr_gnt) begin
         cnt_nxt = '0;
      end else if (cnt != '1) begin
         cnt_nxt = cnt + 1'b1;
      end
   end

   // Flag follows the next count so it rises on the same edge the count reaches the limit
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt         <= '0;
         ldr_starved <= 1'b0;
      end else begin
         cnt         <= cnt_nxt;
         ldr_starved <= (cnt_nxt >= WAIT_W'(STARVE_LIMIT));
      end
   end

endmodule

// File: rtl/ram_port_arbiter.sv
// Single-port RAM arbiter: CPU has absolute, zero-latency priority; loader fills idle cycles.
// Optional starvation monitor enabled by defining ARB_STARVE_MON_EN.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ARB_IDLE   | no loader read in flight
// ARB_LDR_RD | loader read granted last cycle; ram_rdata belongs to loader
module ram_port_arbiter
   import ram_arb_pkg::*;
#(
   parameter int ADDR_W       = ARB_ADDR_W,
   parameter int DATA_W       = ARB_DATA_W,
   parameter int WAIT_W       = ARB_WAIT_W,
   parameter int STARVE_LIMIT = ARB_STARVE_LIMIT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_re,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              ldr_req,
   input  logic              ldr_we,
   input  logic [ADDR_W-1:0] ldr_addr,
   input  logic [DATA_W-1:0] ldr_wdata,
   output logic              ldr_gnt,
   output logic              ldr_rvalid,
   output logic [DATA_W-1:0] ldr_rdata,
   output logic              ldr_starved,
   output logic              cpu_conflict,
   output logic              ram_re,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata
);

   arb_state_t        state;
   arb_state_t        state_nxt;
   logic              cpu_act;
   logic              owner;
   logic              ldr_rd_cap;
   logic [DATA_W-1:0] ldr_rdata_q;

   if (STARVE_LIMIT < 1 || STARVE_LIMIT > (2**WAIT_W) - 1) begin : g_bad_limit
      $error("STARVE_LIMIT must be reachable by a WAIT_W-bit saturating counter");
   end

   assign cpu_act   = cpu_re | cpu_we;
   assign owner     = cpu_act ? OWNER_CPU : OWNER_LDR;
   assign ldr_gnt   = reset & (owner == OWNER_LDR) & ldr_req;
   assign cpu_rdata = ram_rdata;

   // Address/data default to the CPU port so an idle RAM sees stable CPU values
   always_comb begin
      ram_addr  = cpu_addr;
      ram_wdata = cpu_wdata;
      ram_re    = 1'b0;
      ram_we    = 1'b0;
      if (reset) begin
         if (owner == OWNER_CPU) begin
            ram_we = cpu_we;
            ram_re = cpu_re & ~cpu_we;
         end else if (ldr_req) begin
            ram_addr  = ldr_addr;
            ram_wdata = ldr_wdata;
            ram_we    = ldr_we;
            ram_re    = ~ldr_we;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ARB_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = ARB_IDLE;
      case (state)
         ARB_IDLE:   state_nxt = (ldr_gnt && !ldr_we) ? ARB_LDR_RD : ARB_IDLE;
         ARB_LDR_RD: state_nxt = (ldr_gnt && !ldr_we) ? ARB_LDR_RD : ARB_IDLE;
         default:    state_nxt = ARB_IDLE;
      endcase
   end

   always_comb begin
      ldr_rd_cap = 1'b0;
      case (state)
         ARB_LDR_RD: ldr_rd_cap = 1'b1;
         default:    ldr_rd_cap = 1'b0;
      endcase
   end

   assign ldr_rvalid = ldr_rd_cap;

   // RAM returns data one cycle after the strobe: pass it through on the valid
   // cycle, then hold the captured copy until the next loader read returns
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ldr_rdata_q <= '0;
      end else if (ldr_rd_cap) begin
         ldr_rdata_q <= ram_rdata;
      end
   end

   assign ldr_rdata = ldr_rd_cap ? ram_rdata : ldr_rdata_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cpu_conflict <= 1'b0;
      end else if (cpu_re && cpu_we) begin
         cpu_conflict <= 1'b1;
      end
   end

`ifdef ARB_STARVE_MON_EN
   ram_arb_wait_counter #(
      .WAIT_W      (WAIT_W),
      .STARVE_LIMIT(STARVE_LIMIT)
   ) u_wait_counter (
      .clk        (clk),
      .reset      (reset),
      .ldr_req    (ldr_req),
      .ldr_gnt    (ldr_gnt),
      .ldr_starved(ldr_starved)
   );
`else
   assign ldr_starved = 1'b0;
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter with a synchronous RAM model.
// Starvation checks follow ARB_STARVE_MON_EN.
module tb_ram_port_arbiter;

`ifdef ARB_STARVE_MON_EN
   localparam bit MON_ON = 1'b1;
`else
   localparam bit MON_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        cpu_re, cpu_we, ldr_req, ldr_we;
   logic [15:0] cpu_addr, cpu_wdata, ldr_addr, ldr_wdata;
   logic [15:0] cpu_rdata, ldr_rdata, ram_addr, ram_wdata;
   logic [15:0] ram_rdata = 16'h0000;
   logic        ldr_gnt, ldr_rvalid, ldr_starved, cpu_conflict, ram_re, ram_we;

   logic [15:0] mem [0:65535];
   logic [15:0] exp_q [$];
   int          n_vec = 0;
   int          n_err = 0;

   ram_port_arbiter dut (
      .clk         (clk),
      .reset       (reset),
      .cpu_re      (cpu_re),
      .cpu_we      (cpu_we),
      .cpu_addr    (cpu_addr),
      .cpu_wdata   (cpu_wdata),
      .cpu_rdata   (cpu_rdata),
      .ldr_req     (ldr_req),
      .ldr_we      (ldr_we),
      .ldr_addr    (ldr_addr),
      .ldr_wdata   (ldr_wdata),
      .ldr_gnt     (ldr_gnt),
      .ldr_rvalid  (ldr_rvalid),
      .ldr_rdata   (ldr_rdata),
      .ldr_starved (ldr_starved),
      .cpu_conflict(cpu_conflict),
      .ram_re      (ram_re),
      .ram_we      (ram_we),
      .ram_addr    (ram_addr),
      .ram_wdata   (ram_wdata),
      .ram_rdata   (ram_rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      if (ram_re) ram_rdata <= mem[ram_addr];
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Loader read returns are compared in order against the scoreboard
   always @(negedge clk) begin
      if (ldr_rvalid === 1'b1) begin
         if (exp_q.size() == 0) chk("rvalid_unexpected", 32'd1, 32'd0);
         else chk("ldr_rdata_ret", {16'h0, ldr_rdata}, {16'h0, exp_q.pop_front()});
      end
   end

   task automatic drive(input logic c_re, input logic c_we, input logic [15:0] c_addr,
                        input logic [15:0] c_wd, input logic l_req, input logic l_we,
                        input logic [15:0] l_addr, input logic [15:0] l_wd);
      cpu_re    = c_re;
      cpu_we    = c_we;
      cpu_addr  = c_addr;
      cpu_wdata = c_wd;
      ldr_req   = l_req;
      ldr_we    = l_we;
      ldr_addr  = l_addr;
      ldr_wdata = l_wd;
      @(negedge clk);
   endtask

   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
      mem[16'h0010] = 16'h1234;
      mem[16'h0200] = 16'hBEEF;
      mem[16'h0300] = 16'h1111;
      mem[16'h0301] = 16'h2222;

      reset = 1'b1;
      cpu_re = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
      ldr_req = 0; ldr_we = 0; ldr_addr = 0; ldr_wdata = 0;
      #1 reset = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      next_cyc();

      // reset in the middle of a granted loader read
      drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 16'h0200, 16'h0);
      chk("rst_gnt_seen", {31'h0, ldr_gnt}, 32'd1);
      #1 reset = 1'b0;
      ldr_req = 1'b0; ldr_addr = 16'h0;
      @(negedge clk);
      chk("rst_rvalid", {31'h0, ldr_rvalid}, 32'd0);
      chk("rst_rdata", {16'h0, ldr_rdata}, 32'd0);
      chk("rst_gnt", {31'h0, ldr_gnt}, 32'd0);
      chk("rst_ram_re", {31'h0, ram_re}, 32'd0);
      chk("rst_ram_we", {31'h0, ram_we}, 32'd0);
      chk("rst_conflict", {31'h0, cpu_conflict}, 32'd0);
      chk("rst_starved", {31'h0, ldr_starved}, 32'd0);
      chk("rst_ram_addr", {16'h0, ram_addr}, 32'd0);
      @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      chk("post_rst_re", {31'h0, ram_re}, 32'd0);
      chk("post_rst_we", {31'h0, ram_we}, 32'd0);
      chk("post_rst_rvalid", {31'h0, ldr_rvalid}, 32'd0);
      next_cyc();

      // CPU priority, then loader read of 0x0200
      drive(1'b1, 1'b0, 16'h0010, 16'h0, 1'b1, 1'b0, 16'h0200, 16'h0);
      chk("prio_addr", {16'h0, ram_addr}, 32'h0010);
      chk("prio_gnt", {31'h0, ldr_gnt}, 32'd0);
      chk("prio_re", {31'h0, ram_re}, 32'd1);
      next_cyc();
      exp_q.push_back(16'hBEEF);
      drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 16'h0200, 16'h0);
      chk("ldr_gnt", {31'h0, ldr_gnt}, 32'd1);
      chk("ldr_addr", {16'h0, ram_addr}, 32'h0200);
      chk("ldr_re", {31'h0, ram_re}, 32'd1);
      next_cyc();

      // return arrives while the CPU reads 0x0010; CPU data must not disturb ldr_rdata
      drive(1'b1, 1'b0, 16'h0010, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
      chk("ret_rvalid", {31'h0, ldr_rvalid}, 32'd1);
      chk("ret_rdata", {16'h0, ldr_rdata}, 32'hBEEF);
      next_cyc();
      idle();
      chk("cpu_rd_0010", {16'h0, cpu_rdata}, 32'h1234);
      chk("hold_rdata", {16'h0, ldr_rdata}, 32'hBEEF);
      chk("hold_rvalid", {31'h0, ldr_rvalid}, 32'd0);
      next_cyc();

      // back-to-back loader reads, then a loader write read back by the CPU
      exp_q.push_back(16'h1111);
      drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 16'h0300, 16'h0);
      chk("b2b_gnt0", {31'h0, ldr_gnt}, 32'd1);
      next_cyc();
      exp_q.push_back(16'h2222);
      drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 16'h0301, 16'h0);
      chk("b2b_gnt1", {31'h0, ldr_gnt}, 32'd1);
      chk("b2b_rv0", {31'h0, ldr_rvalid}, 32'd1);
      next_cyc();
      drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b1, 16'h0400, 16'hA5A5);
      chk("lw_gnt", {31'h0, ldr_gnt}, 32'd1);
      chk("lw_we", {31'h0, ram_we}, 32'd1);
      chk("lw_wdata", {16'h0, ram_wdata}, 32'hA5A5);
      chk("b2b_rv1", {31'h0, ldr_rvalid}, 32'd1);
      next_cyc();
      drive(1'b1, 1'b0, 16'h0400, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
      chk("lw_no_rv", {31'h0, ldr_rvalid}, 32'd0);
      next_cyc();
      idle();
      chk("cpu_rd_0400", {16'h0, cpu_rdata}, 32'hA5A5);
      next_cyc();

      // read+write conflict: write wins, flag sticks
      drive(1'b1, 1'b1, 16'h0020, 16'h5555, 1'b1, 1'b0, 16'h0300, 16'h0);
      chk("cf_we", {31'h0, ram_we}, 32'd1);
      chk("cf_re", {31'h0, ram_re}, 32'd0);
      chk("cf_gnt", {31'h0, ldr_gnt}, 32'd0);
      next_cyc();
      idle();
      chk("cf_sticky0", {31'h0, cpu_conflict}, 32'd1);
      next_cyc();
      drive(1'b1, 1'b0, 16'h0020, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
      next_cyc();
      idle();
      chk("cf_rd_0020", {16'h0, cpu_rdata}, 32'h5555);
      chk("cf_sticky1", {31'h0, cpu_conflict}, 32'd1);
      next_cyc();

      // starvation: loader held off by 64 CPU cycles
      for (int k = 1; k <= 64; k++) begin
         drive(1'b1, 1'b0, 16'h0010, 16'h0, 1'b1, 1'b0, 16'h0300, 16'h0);
         if (k == 1 || k == 64) begin
            chk("stv_gnt", {31'h0, ldr_gnt}, 32'd0);
            chk("stv_early", {31'h0, ldr_starved}, 32'd0);
         end
         next_cyc();
      end
      exp_q.push_back(16'h1111);
      drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 16'h0300, 16'h0);
      chk("stv_gnt_idle", {31'h0, ldr_gnt}, 32'd1);
      chk("stv_flag", {31'h0, ldr_starved}, {31'h0, MON_ON});
      next_cyc();
      idle();
      chk("stv_clear", {31'h0, ldr_starved}, 32'd0);
      next_cyc();
      idle();
      chk("queue_empty", exp_q.size(), 32'd0);

      #1 reset = 1'b0;
      @(negedge clk);
      chk("cf_reset", {31'h0, cpu_conflict}, 32'd0);
      #1 reset = 1'b1;
      next_cyc();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
